// File: rtl/poly_result_fold.sv
// Reads a 2N-bit product c(x) from the result RAM and reduces it modulo (x^N - 1).
// The folded result r[i] = c[i] ^ c[i+N] is streamed out as 4-word beats on valid/ready.
module poly_result_fold #(
  parameter int N          = 17669,
  parameter int RAMWIDTH   = 32,
  parameter int X          = 1106,
  parameter int ADDR_WIDTH = 11,
  parameter int NW         = 553,
  parameter int Q          = 552,
  parameter int S          = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic [ADDR_WIDTH-1:0]   res_addr,
  output logic                    res_rd,
  input  logic [RAMWIDTH-1:0]     res_dout,
  output logic [4*RAMWIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy_o,
  output logic                    done
);

  localparam int KW = $clog2(NW + 1);
  localparam logic [RAMWIDTH-1:0] LAST_MASK =
    (S == 0) ? {RAMWIDTH{1'b1}} : RAMWIDTH'((64'd1 << S) - 64'd1);

  if ((Q + NW > X - 1) || (N != Q * RAMWIDTH + S)) begin : g_param_check
    $error("poly_result_fold: inconsistent N/Q/S/NW/X parameters");
  end

  typedef enum logic [2:0] {IDLE, PRIME, RD_HI, RD_LO, COMBINE, EMIT, FIN} state_t;

  state_t                  state_q;
  logic [KW-1:0]           k_q;
  logic                    prime_q;
  logic [RAMWIDTH-1:0]     hi_prev_q;
  logic [RAMWIDTH-1:0]     hi_cur_q;
  logic [4*RAMWIDTH-1:0]   pack_q;

  logic [RAMWIDTH-1:0]     fold_hi;
  logic [RAMWIDTH-1:0]     w;
  logic [4*RAMWIDTH-1:0]   pack_d;
  logic                    last_k;
  logic                    lane3;

  // Address of the high-half word that pairs with result word kk.
  function automatic logic [ADDR_WIDTH-1:0] addr_hi(input logic [KW-1:0] kk);
    return ADDR_WIDTH'(Q + 1 + int'(kk));
  endfunction

  assign last_k = (k_q == KW'(NW - 1));
  assign lane3  = (k_q[1:0] == 2'd3);

  // The low word is consumed straight off the RAM port in the cycle it returns (COMBINE).
  always_comb begin
    fold_hi = hi_prev_q;
    if (S != 0) fold_hi = (hi_prev_q >> S) | (hi_cur_q << (RAMWIDTH - S));
    w = res_dout ^ fold_hi;
    if (last_k) w = w & LAST_MASK;
    pack_d = pack_q;
    pack_d[RAMWIDTH*int'(k_q[1:0]) +: RAMWIDTH] = w;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      prime_q   <= 1'b0;
      pack_q    <= '0;
      res_addr  <= '0;
      res_rd    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy_o    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_o   <= 1'b1;
            k_q      <= '0;
            pack_q   <= '0;
            res_rd   <= 1'b1;
            res_addr <= ADDR_WIDTH'(Q);
            state_q  <= PRIME;
          end
        end
        PRIME: begin
          prime_q  <= 1'b1;
          res_rd   <= 1'b1;
          res_addr <= addr_hi(k_q);
          state_q  <= RD_HI;
        end
        RD_HI: begin
          prime_q  <= 1'b0;
          res_rd   <= 1'b1;
          res_addr <= ADDR_WIDTH'(k_q);
          state_q  <= RD_LO;
        end
        RD_LO: begin
          res_rd  <= 1'b0;
          state_q <= COMBINE;
        end
        COMBINE: begin
          pack_q <= pack_d;
          if (lane3 || last_k) begin
            out_data  <= pack_d;
            out_valid <= 1'b1;
            state_q   <= EMIT;
          end else begin
            k_q      <= k_q + KW'(1);
            res_rd   <= 1'b1;
            res_addr <= addr_hi(k_q + KW'(1));
            state_q  <= RD_HI;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            pack_q    <= '0;
            if (last_k) begin
              done    <= 1'b1;
              state_q <= FIN;
            end else begin
              k_q      <= k_q + KW'(1);
              res_rd   <= 1'b1;
              res_addr <= addr_hi(k_q + KW'(1));
              state_q  <= RD_HI;
            end
          end
        end
        FIN: begin
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data lands one cycle after its issue; hi_prev is seeded once from word Q.
  always_ff @(posedge clk) begin
    if (state_q == RD_HI && prime_q) hi_prev_q <= res_dout;
    if (state_q == RD_LO)            hi_cur_q  <= res_dout;
    if (state_q == COMBINE)          hi_prev_q <= hi_cur_q;
  end

endmodule

// File: tb/tb_poly_result_fold.sv
// Directed bench for poly_result_fold: a behavioural result RAM, a bit-level
// mod (x^N - 1) reference, and hand-derived values for the corner vectors.
module tb_poly_result_fold;

  localparam int N  = 17669;
  localparam int RW = 32;
  localparam int X  = 1106;
  localparam int AW = 11;
  localparam int NW = 553;
  localparam int Q  = 552;
  localparam int S  = 5;
  localparam int NB = 139;
  localparam int BUDGET = 6000;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] res_addr;
  logic          res_rd;
  logic [31:0]   res_dout;
  logic [127:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy_o;
  logic          done;

  logic [31:0]   mem   [X];
  logic [31:0]   exp_w [NW];
  logic [127:0]  got   [NB];

  int checks   = 0;
  int failures = 0;

  poly_result_fold #(
    .N(N), .RAMWIDTH(RW), .X(X), .ADDR_WIDTH(AW), .NW(NW), .Q(Q), .S(S)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .res_addr(res_addr), .res_rd(res_rd), .res_dout(res_dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy_o(busy_o), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result RAM: data valid one cycle after the read-enable cycle.
  always @(posedge clk) if (res_rd) res_dout <= mem[res_addr];

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  task automatic clear_mem(input logic [31:0] v);
    for (int a = 0; a < X; a++) mem[a] = v;
  endtask

  function automatic void build_golden();
    for (int i = 0; i < NW; i++) exp_w[i] = '0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = i + N;
      exp_w[i/32][i%32] = mem[i/32][i%32] ^ mem[j/32][j%32];
    end
  endfunction

  function automatic logic [127:0] exp_beat(input int b);
    logic [127:0] v;
    v = '0;
    for (int m = 0; m < 4; m++)
      if (4*b + m < NW) v[32*m +: 32] = exp_w[4*b + m];
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 128'(out_valid), 128'd0);
    check_eq({tag, "_data"},  out_data,        128'd0);
    check_eq({tag, "_rd"},    128'(res_rd),    128'd0);
    check_eq({tag, "_addr"},  128'(res_addr),  128'd0);
    check_eq({tag, "_busy"},  128'(busy_o),    128'd0);
    check_eq({tag, "_done"},  128'(done),      128'd0);
  endtask

  // Runs one fold; rnd randomises out_ready, abort_at >= 0 resets mid-stream.
  task automatic run_case(input string tag, input bit rnd, input int abort_at);
    int           idx, cyc, first_v;
    bit           seen_done, prev_hold, addr_bad, aborted;
    logic [127:0] prev_data;
    build_golden();
    for (int b = 0; b < NB; b++) got[b] = '0;
    idx = 0; cyc = 0; first_v = -1;
    seen_done = 0; prev_hold = 0; addr_bad = 0; aborted = 0; prev_data = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < BUDGET) begin
      if (res_rd && int'(res_addr) >= X) addr_bad = 1;
      if (prev_hold) begin
        check_eq({tag, "_hold_vld"},  128'(out_valid), 128'd1);
        check_eq({tag, "_hold_data"}, out_data,        prev_data);
      end
      if (out_valid && first_v < 0) first_v = cyc;
      if (done) begin
        seen_done = 1;
        check_eq({tag, "_busy_at_done"}, 128'(busy_o), 128'd1);
        break;
      end
      if (abort_at >= 0 && idx == abort_at) begin
        aborted = 1;
        break;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      if (out_valid && out_ready) begin
        if (idx < NB) got[idx] = out_data;
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (aborted) begin
      rst_n = 1'b0;
      out_ready = 1'b0;
      @(posedge clk); #1;
      check_reset_outputs({tag, "_midrst"});
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_eq({tag, "_postrst_idle"}, 128'(busy_o), 128'd0);
    end else begin
      check_eq({tag, "_done_seen"}, 128'(seen_done), 128'd1);
      check_eq({tag, "_beats"},     128'(idx),       128'(NB));
      check_eq({tag, "_addr_range"}, 128'(addr_bad), 128'd0);
      if (!rnd) check_eq({tag, "_latency"}, 128'(first_v), 128'd13);
      for (int b = 0; b < NB; b++)
        check_eq($sformatf("%s_beat%0d", tag, b), got[b], exp_beat(b));
      out_ready = 1'b0;
      @(posedge clk); #1;
      check_eq({tag, "_busy_after"}, 128'(busy_o), 128'd0);
      check_eq({tag, "_done_pulse"}, 128'(done),   128'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    clear_mem('0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // c[0] only
    clear_mem('0); mem[0] = 32'h1;
    run_case("c0", 0, -1);
    check_eq("c0_hand_b0",   got[0],   128'h1);
    check_eq("c0_hand_b138", got[138], 128'h0);

    // c[N] folds onto r[0]
    clear_mem('0); mem[552] = 32'h20;
    run_case("cN", 0, -1);
    check_eq("cN_hand_b0", got[0], 128'h1);

    // c[0] and c[N] cancel
    clear_mem('0); mem[0] = 32'h1; mem[552] = 32'h20;
    run_case("cancel", 0, -1);
    check_eq("cancel_hand_b0", got[0], 128'h0);

    // c[2N-2] = word 1104 bit 8 -> r[N-2] = beat 138 lane 0 bit 3
    clear_mem('0); mem[1104] = 32'h100;
    run_case("top", 0, -1);
    check_eq("top_hand_b138", got[138], 128'h8);
    check_eq("top_hand_b0",   got[0],   128'h0);

    // all ones cancel everywhere
    clear_mem(32'hFFFF_FFFF);
    run_case("ones", 0, -1);
    check_eq("ones_hand_b0",   got[0],   128'h0);
    check_eq("ones_hand_b138", got[138], 128'h0);

    // word 552 all ones: top bits fold to r[0..26], last word keeps only 5 bits
    clear_mem('0); mem[552] = 32'hFFFF_FFFF;
    run_case("mask", 0, -1);
    check_eq("mask_hand_b0",   got[0],   128'h07FF_FFFF);
    check_eq("mask_hand_b138", got[138], 128'h1F);

    // random product under random backpressure
    for (int a = 0; a < X; a++) mem[a] = $urandom;
    run_case("rnd_bp", 1, -1);

    // reset in beat 50, then a complete rerun
    for (int a = 0; a < X; a++) mem[a] = $urandom;
    run_case("abort", 1, 50);
    run_case("rerun", 1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
